// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded forwarding register file.
// Bypass indices name the pipeline stage feeding each result bus.
package regfile_sb_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int NRD_DEF  = 2;
    localparam int NBYP_DEF = 3;

    localparam int REG_ZERO = 0;

    localparam int BYP_EX  = 0;
    localparam int BYP_MEM = 1;
    localparam int BYP_WB  = 2;

endpackage

// File: rtl/rf_read_port.sv
// One operand read port: bypass/commit/array priority mux.
// ok reflects whichever source wins, not the scoreboard alone.
module rf_read_port
    import regfile_sb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int NBYP = NBYP_DEF
) (
    input  logic [AW-1:0]      addr,
    input  logic [NBYP-1:0]    byp_we,
    input  logic [NBYP-1:0]    byp_rdy,
    input  logic [NBYP*AW-1:0] byp_addr,
    input  logic [NBYP*DW-1:0] byp_data,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic [DW-1:0]      reg_data,
    input  logic               reg_busy,
    output logic [DW-1:0]      data,
    output logic               ok
);

    always_comb begin
        data = reg_data;
        ok   = ~reg_busy;
        if (we && waddr == addr) begin
            data = wdata;
            ok   = 1'b1;
        end
        // Oldest first so the youngest matching source lands last.
        for (int i = NBYP - 1; i >= 0; i--) begin
            if (byp_we[i] && byp_addr[i*AW +: AW] == addr) begin
                data = byp_data[i*DW +: DW];
                ok   = byp_rdy[i];
            end
        end
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
            ok   = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file with bypass network and busy scoreboard.
// Raises stall when a needed operand is not yet available.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int NBYP = NBYP_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NRD-1:0]     rd_en,
    input  logic [NRD*AW-1:0]  rd_addr,
    output logic [NRD*DW-1:0]  rd_data,
    output logic [NRD-1:0]     rd_ok,
    output logic               stall,
    input  logic [NBYP-1:0]    byp_we,
    input  logic [NBYP-1:0]    byp_rdy,
    input  logic [NBYP*AW-1:0] byp_addr,
    input  logic [NBYP*DW-1:0] byp_data,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic               sb_set,
    input  logic [AW-1:0]      sb_addr
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we && waddr != AW'(REG_ZERO)) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        // A newly issued producer supersedes the one committing now.
        if (sb_set && sb_addr != AW'(REG_ZERO)) begin
            busy_d[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0] a;
        assign a = rd_addr[p*AW +: AW];

        rf_read_port #(
            .DW   (DW),
            .AW   (AW),
            .NBYP (NBYP)
        ) u_port (
            .addr     (a),
            .byp_we   (byp_we),
            .byp_rdy  (byp_rdy),
            .byp_addr (byp_addr),
            .byp_data (byp_data),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .reg_data (regs_q[a]),
            .reg_busy (busy_q[a]),
            .data     (rd_data[p*DW +: DW]),
            .ok       (rd_ok[p])
        );
    end

    assign stall = |(rd_en & ~rd_ok);

endmodule
